// File: rtl/mips_mem_arbiter_if.sv
// RAM-side bus of the instruction/data memory arbiter: cs/ack handshake,
// registered address/write data from the arbiter, read data and ack from the RAM.
interface mips_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  cs;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    logic                  ack;

    modport master (output cs, we, addr, din, input dout, ack);
    modport slave  (input cs, we, addr, din, output dout, ack);
endinterface

// File: rtl/mips_mem_arbiter.sv
// Serializes instruction fetch and data access onto one single-port RAM (data first).
// Optional macro ARB_TIMEOUT_EN aborts accesses whose ram_ack never arrives.
module mips_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_ren,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    output logic [DATA_WIDTH-1:0] inst_data,
    input  logic                  d_ren,
    input  logic                  d_wen,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  stall,
    mips_mem_arbiter_if.master    ram,
    output logic                  err
);
    typedef enum logic [1:0] {IDLE, D_ACC, I_ACC} state_t;

    state_t state, state_nxt;
    logic   i_done, d_done;
    logic   i_pend, d_pend;
    logic   abort, finish;
    logic   load_d, load_i, set_d_done, set_i_done;
    logic [DATA_WIDTH-1:0] rd_word;

    assign i_pend = inst_ren & ~i_done;
    assign d_pend = (d_ren | d_wen) & ~d_done;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] tmo_cnt;

    // Abort on the cycle whose missing ack would bring the count up to TIMEOUT.
    assign abort = (state != IDLE) && !ram.ack && (tmo_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst)                tmo_cnt <= '0;
        else if (state == IDLE) tmo_cnt <= '0;
        else if (!ram.ack)      tmo_cnt <= tmo_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)        err <= 1'b0;
        else if (abort) err <= 1'b1;
    end
`else
    assign abort = 1'b0;
    assign err   = 1'b0;
`endif

    assign finish = (state != IDLE) && (ram.ack || abort);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (d_pend)      state_nxt = D_ACC;
                else if (i_pend) state_nxt = I_ACC;
            end
            D_ACC, I_ACC: if (finish) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stall      = i_pend | d_pend;
        load_d     = (state == IDLE) && d_pend;
        load_i     = (state == IDLE) && !d_pend && i_pend;
        set_d_done = (state == D_ACC) && finish;
        set_i_done = (state == I_ACC) && finish;
        rd_word    = abort ? '1 : ram.dout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram.cs    <= 1'b0;
            ram.we    <= 1'b0;
            ram.addr  <= '0;
            ram.din   <= '0;
            inst_data <= '0;
            d_rdata   <= '0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
        end else begin
            if (load_d) begin
                ram.addr <= d_addr;
                ram.din  <= d_wdata;
                ram.we   <= d_wen;
                ram.cs   <= 1'b1;
            end else if (load_i) begin
                ram.addr <= inst_addr;
                ram.we   <= 1'b0;
                ram.cs   <= 1'b1;
            end else if (finish) begin
                ram.cs <= 1'b0;
                ram.we <= 1'b0;
            end

            // ram.we still reflects the finishing access, so stores never touch d_rdata.
            if (set_d_done && !ram.we) d_rdata <= rd_word;
            if (set_i_done)            inst_data <= rd_word;

            // The core advances on any edge without stall; served ports start afresh.
            if (!stall) begin
                i_done <= 1'b0;
                d_done <= 1'b0;
            end else begin
                if (set_i_done) i_done <= 1'b1;
                if (set_d_done) d_done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Cycle-accurate vector table plus hand-written multi-cycle sequences for mips_mem_arbiter.
// Define ARB_TIMEOUT_EN (for both DUT and bench) to also exercise the timeout abort.
module tb_mips_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          inst_ren;
    logic [AW-1:0] inst_addr;
    logic [DW-1:0] inst_data;
    logic          d_ren, d_wen;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          stall, err;

    int n_checks = 0;
    int n_fail   = 0;

    mips_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ram_if ();

    mips_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .inst_ren  (inst_ren),
        .inst_addr (inst_addr),
        .inst_data (inst_data),
        .d_ren     (d_ren),
        .d_wen     (d_wen),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .stall     (stall),
        .ram       (ram_if.master),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          iren;
        logic [31:0]   iaddr;
        logic          dren;
        logic          dwen;
        logic [31:0]   daddr;
        logic [31:0]   dwdata;
        logic [31:0]   dout;
        logic          ack;
        logic          e_stall;
        logic          e_cs;
        logic          e_we;
        logic [31:0]   e_addr;
        logic [31:0]   e_din;
        logic [31:0]   e_idata;
        logic [31:0]   e_drdata;
    } vec_t;

    vec_t vecs[30];

    function automatic vec_t mk(logic r, logic ir, logic [31:0] ia, logic dr, logic dw,
                                logic [31:0] da, logic [31:0] wd, logic [31:0] dout,
                                logic ack, logic s, logic cs, logic we, logic [31:0] a,
                                logic [31:0] din, logic [31:0] id, logic [31:0] drd);
        vec_t v;
        v.rst = r; v.iren = ir; v.iaddr = ia; v.dren = dr; v.dwen = dw; v.daddr = da;
        v.dwdata = wd; v.dout = dout; v.ack = ack; v.e_stall = s; v.e_cs = cs;
        v.e_we = we; v.e_addr = a; v.e_din = din; v.e_idata = id; v.e_drdata = drd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst       = v.rst;
        inst_ren  = v.iren;
        inst_addr = v.iaddr;
        d_ren     = v.dren;
        d_wen     = v.dwen;
        d_addr    = v.daddr;
        d_wdata   = v.dwdata;
        ram_if.dout = v.dout;
        ram_if.ack  = v.ack;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; inst_ren = 1'b0; inst_addr = '0; d_ren = 1'b0; d_wen = 1'b0;
        d_addr = '0; d_wdata = '0; ram_if.dout = '0; ram_if.ack = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        // Each row: inputs for one cycle, and the outputs expected during that cycle
        // (registered outputs from the previous edge, stall from this cycle's inputs).
        //              rst ir iaddr       dr dw daddr       wdata         dout          ack | st cs we addr        din           idata         drdata
        vecs[0]  = mk(0, 0, 32'h0,     0, 0, 32'h0,  32'h0,        32'h0,        0,   0, 0, 0, 32'h0,   32'h0,        32'h0,        32'h0);
        // Instruction-only fetch, ack in the first cs cycle
        vecs[1]  = mk(0, 1, 32'h100,   0, 0, 32'h0,  32'h0,        32'h0,        0,   1, 0, 0, 32'h0,   32'h0,        32'h0,        32'h0);
        vecs[2]  = mk(0, 1, 32'h100,   0, 0, 32'h0,  32'h0,        32'h2408000A, 1,   1, 1, 0, 32'h100, 32'h0,        32'h0,        32'h0);
        vecs[3]  = mk(0, 1, 32'h100,   0, 0, 32'h0,  32'h0,        32'h0,        0,   0, 0, 0, 32'h100, 32'h0,        32'h2408000A, 32'h0);
        vecs[4]  = mk(0, 0, 32'h0,     0, 0, 32'h0,  32'h0,        32'h0,        0,   0, 0, 0, 32'h100, 32'h0,        32'h2408000A, 32'h0);
        // Stray ack in IDLE
        vecs[5]  = mk(0, 0, 32'h0,     0, 0, 32'h0,  32'h0,        32'h55555555, 1,   0, 0, 0, 32'h100, 32'h0,        32'h2408000A, 32'h0);
        vecs[6]  = mk(0, 0, 32'h0,     0, 0, 32'h0,  32'h0,        32'h0,        0,   0, 0, 0, 32'h100, 32'h0,        32'h2408000A, 32'h0);
        // Store with read flag also set: write wins, d_rdata untouched
        vecs[7]  = mk(0, 0, 32'h0,     1, 1, 32'h80, 32'hDEADBEEF, 32'h0,        0,   1, 0, 0, 32'h100, 32'h0,        32'h2408000A, 32'h0);
        vecs[8]  = mk(0, 0, 32'h0,     1, 1, 32'h80, 32'hDEADBEEF, 32'h12345678, 1,   1, 1, 1, 32'h80,  32'hDEADBEEF, 32'h2408000A, 32'h0);
        vecs[9]  = mk(0, 0, 32'h0,     1, 1, 32'h80, 32'hDEADBEEF, 32'h0,        0,   0, 0, 0, 32'h80,  32'hDEADBEEF, 32'h2408000A, 32'h0);
        vecs[10] = mk(0, 0, 32'h0,     0, 0, 32'h0,  32'h0,        32'h0,        0,   0, 0, 0, 32'h80,  32'hDEADBEEF, 32'h2408000A, 32'h0);
        // Simultaneous load and fetch, ack in the second cs cycle of each access
        vecs[11] = mk(0, 1, 32'h104,   1, 0, 32'h40, 32'h0,        32'h0,        0,   1, 0, 0, 32'h80,  32'hDEADBEEF, 32'h2408000A, 32'h0);
        vecs[12] = mk(0, 1, 32'h104,   1, 0, 32'h40, 32'h0,        32'h0,        0,   1, 1, 0, 32'h40,  32'h0,        32'h2408000A, 32'h0);
        vecs[13] = mk(0, 1, 32'h104,   1, 0, 32'h40, 32'h0,        32'hAAAA0001, 1,   1, 1, 0, 32'h40,  32'h0,        32'h2408000A, 32'h0);
        vecs[14] = mk(0, 1, 32'h104,   1, 0, 32'h40, 32'h0,        32'h0,        0,   1, 0, 0, 32'h40,  32'h0,        32'h2408000A, 32'hAAAA0001);
        vecs[15] = mk(0, 1, 32'h104,   1, 0, 32'h40, 32'h0,        32'h0,        0,   1, 1, 0, 32'h104, 32'h0,        32'h2408000A, 32'hAAAA0001);
        vecs[16] = mk(0, 1, 32'h104,   1, 0, 32'h40, 32'h0,        32'h3C010000, 1,   1, 1, 0, 32'h104, 32'h0,        32'h2408000A, 32'hAAAA0001);
        vecs[17] = mk(0, 1, 32'h104,   1, 0, 32'h40, 32'h0,        32'h0,        0,   0, 0, 0, 32'h104, 32'h0,        32'h3C010000, 32'hAAAA0001);
        vecs[18] = mk(0, 0, 32'h0,     0, 0, 32'h0,  32'h0,        32'h0,        0,   0, 0, 0, 32'h104, 32'h0,        32'h3C010000, 32'hAAAA0001);
        // Reset in I_ACC, late ack ignored
        vecs[19] = mk(0, 1, 32'h200,   0, 0, 32'h0,  32'h0,        32'h0,        0,   1, 0, 0, 32'h104, 32'h0,        32'h3C010000, 32'hAAAA0001);
        vecs[20] = mk(1, 1, 32'h200,   0, 0, 32'h0,  32'h0,        32'h0,        0,   1, 1, 0, 32'h200, 32'h0,        32'h3C010000, 32'hAAAA0001);
        vecs[21] = mk(0, 0, 32'h0,     0, 0, 32'h0,  32'h0,        32'h99,       1,   0, 0, 0, 32'h0,   32'h0,        32'h0,        32'h0);
        vecs[22] = mk(0, 0, 32'h0,     0, 0, 32'h0,  32'h0,        32'h0,        0,   0, 0, 0, 32'h0,   32'h0,        32'h0,        32'h0);
        // Fetch dropped while in flight: completes and latches, but does not count as served
        vecs[23] = mk(0, 1, 32'h300,   0, 0, 32'h0,  32'h0,        32'h0,        0,   1, 0, 0, 32'h0,   32'h0,        32'h0,        32'h0);
        vecs[24] = mk(0, 0, 32'h0,     0, 0, 32'h0,  32'h0,        32'h0,        0,   0, 1, 0, 32'h300, 32'h0,        32'h0,        32'h0);
        vecs[25] = mk(0, 0, 32'h0,     0, 0, 32'h0,  32'h0,        32'h77,       1,   0, 1, 0, 32'h300, 32'h0,        32'h0,        32'h0);
        vecs[26] = mk(0, 0, 32'h0,     0, 0, 32'h0,  32'h0,        32'h0,        0,   0, 0, 0, 32'h300, 32'h0,        32'h77,       32'h0);
        vecs[27] = mk(0, 1, 32'h300,   0, 0, 32'h0,  32'h0,        32'h0,        0,   1, 0, 0, 32'h300, 32'h0,        32'h77,       32'h0);
        vecs[28] = mk(0, 1, 32'h300,   0, 0, 32'h0,  32'h0,        32'h88,       1,   1, 1, 0, 32'h300, 32'h0,        32'h77,       32'h0);
        vecs[29] = mk(0, 1, 32'h300,   0, 0, 32'h0,  32'h0,        32'h0,        0,   0, 0, 0, 32'h300, 32'h0,        32'h88,       32'h0);

        do_reset();
        for (int i = 0; i < 30; i++) begin
            drive(vecs[i]);
            #2;
            check($sformatf("row%0d stall", i),     {31'b0, stall},      {31'b0, vecs[i].e_stall});
            check($sformatf("row%0d ram_cs", i),    {31'b0, ram_if.cs},  {31'b0, vecs[i].e_cs});
            check($sformatf("row%0d ram_we", i),    {31'b0, ram_if.we},  {31'b0, vecs[i].e_we});
            check($sformatf("row%0d ram_addr", i),  ram_if.addr,         vecs[i].e_addr);
            check($sformatf("row%0d ram_din", i),   ram_if.din,          vecs[i].e_din);
            check($sformatf("row%0d inst_data", i), inst_data,           vecs[i].e_idata);
            check($sformatf("row%0d d_rdata", i),   d_rdata,             vecs[i].e_drdata);
            check($sformatf("row%0d err", i),       {31'b0, err},        32'h0);
            @(posedge clk);
            #1;
        end

        // Load + fetch against a RAM that acks in the second cs cycle: data goes first,
        // each port is accessed exactly once, and stall stays high for 6 cycles.
        begin
            int          cs_age = 0;
            int          stall_cycles = 0;
            int          accesses = 0;
            logic        cs_prev = 1'b0;
            logic [31:0] first_addr = '1;
            logic        released = 1'b0;
            do_reset();
            d_ren = 1'b1; d_addr = 32'h40; inst_ren = 1'b1; inst_addr = 32'h104;
            for (int c = 0; c < 40 && !released; c++) begin
                cs_age = ram_if.cs ? cs_age + 1 : 0;
                ram_if.ack  = ram_if.cs && (cs_age == 2);
                ram_if.dout = (ram_if.addr == 32'h40) ? 32'hCAFE0040 : 32'h8C0A0104;
                if (ram_if.cs && !cs_prev) begin
                    accesses++;
                    if (accesses == 1) first_addr = ram_if.addr;
                end
                cs_prev = ram_if.cs;
                #2;
                if (stall) stall_cycles++;
                else       released = 1'b1;
                if (!released) begin
                    @(posedge clk);
                    #1;
                end
            end
            check("dual release_within_budget", {31'b0, released}, 32'h1);
            check("dual stall_cycles", stall_cycles, 6);
            check("dual access_count", accesses, 2);
            check("dual first_addr", first_addr, 32'h40);
            check("dual d_rdata", d_rdata, 32'hCAFE0040);
            check("dual inst_data", inst_data, 32'h8C0A0104);
            check("dual cs_low_at_release", {31'b0, ram_if.cs}, 32'h0);
            ram_if.ack = 1'b0;
            @(posedge clk);
            #1 idle_inputs();
        end

`ifdef ARB_TIMEOUT_EN
        // Load to a RAM that never acks: 8 cs cycles, then abort with all-ones data.
        begin
            int   cs_cycles = 0;
            logic released = 1'b0;
            do_reset();
            d_ren = 1'b1; d_addr = 32'h10;
            for (int c = 0; c < 30 && !released; c++) begin
                #2;
                if (ram_if.cs) cs_cycles++;
                if (!stall) released = 1'b1;
                else begin
                    @(posedge clk);
                    #1;
                end
            end
            check("tmo release_within_budget", {31'b0, released}, 32'h1);
            check("tmo cs_cycles", cs_cycles, 8);
            check("tmo d_rdata", d_rdata, 32'hFFFFFFFF);
            check("tmo err", {31'b0, err}, 32'h1);
            @(posedge clk);
            #1 d_ren = 1'b0;
            repeat (3) @(posedge clk);
            #1 check("tmo err_sticky", {31'b0, err}, 32'h1);
            do_reset();
            #1 check("tmo err_cleared", {31'b0, err}, 32'h0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
